// File: rtl/washer_ctrl.sv
// Washing-machine program controller: sequences FILL -> WASH -> DRAIN -> SPIN with pause/resume and power toggle.
// Optional feature macro AUTO_POWER_OFF_EN: inactivity timeout (IDLE_TIMEOUT ticks) in IDLE/DONE powers the unit off.
//
// state   | meaning
// OFF     | unpowered, only power_btn accepted
// IDLE    | powered, program selectable, waiting for start
// FILL    | adding water each tick up to WATER_LVL
// WASH    | counting down the wash portion of the program
// DRAIN   | removing water each tick down to 0
// SPIN    | counting down the spin portion of the program
// DONE    | program finished, beeping until start/mode
// PAUSE   | running state frozen, start resumes it
module washer_ctrl #(
   parameter int WASH_T    = 20,
   parameter int SPIN_T    = 10,
   parameter int WATER_LVL = 40,
   parameter int FILL_STEP = 10
`ifdef AUTO_POWER_OFF_EN
   ,parameter int IDLE_TIMEOUT = 60
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       power_btn,
   input  logic       start_btn,
   input  logic       mode_btn,
   output logic       power_light,
   output logic [6:0] current_time,
   output logic [6:0] total_time,
   output logic [6:0] current_water,
   output logic [2:0] phase,
   output logic [1:0] mode,
   output logic       done_beep
);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_IDLE  = 3'd1,
      S_FILL  = 3'd2,
      S_WASH  = 3'd3,
      S_DRAIN = 3'd4,
      S_SPIN  = 3'd5,
      S_DONE  = 3'd6,
      S_PAUSE = 3'd7
   } state_t;

   localparam logic [6:0] WASH_C = 7'(WASH_T);
   localparam logic [6:0] SPIN_C = 7'(SPIN_T);
   localparam logic [6:0] LVL_C  = 7'(WATER_LVL);
   localparam logic [6:0] STEP_C = 7'(FILL_STEP);
   localparam logic [7:0] LVL8   = 8'(WATER_LVL);
   localparam logic [7:0] STEP8  = 8'(FILL_STEP);

   state_t     state_q, state_d;
   state_t     saved_q, saved_d;
   logic [1:0] mode_q, mode_d;
   logic [6:0] time_q, time_d;
   logic [6:0] total_q, total_d;
   logic [6:0] water_q, water_d;
   logic       power_q, power_d;
   logic       beep_q, beep_d;

   logic [7:0] water_sum;
   logic [6:0] water_up;
   logic [6:0] water_dn;
   logic [6:0] time_dec;
   logic [6:0] wash_end;
   logic [1:0] mode_nxt;
   logic       auto_off;

`ifdef AUTO_POWER_OFF_EN
   localparam logic [6:0] TIMEOUT_C = 7'(IDLE_TIMEOUT);
   logic [6:0] idle_cnt_q, idle_cnt_d;
`endif

   function automatic logic [6:0] total_of(input logic [1:0] m);
      logic [6:0] t;
      case (m)
         2'd0:    t = WASH_C + SPIN_C;
         2'd1:    t = WASH_C;
         default: t = SPIN_C;
      endcase
      return t;
   endfunction

   always_comb begin
      state_d  = state_q;
      saved_d  = saved_q;
      mode_d   = mode_q;
      time_d   = time_q;
      total_d  = total_q;
      water_d  = water_q;
      power_d  = power_q;
      beep_d   = beep_q;
      auto_off = 1'b0;

      water_sum = {1'b0, water_q} + STEP8;
      water_up  = (water_sum >= LVL8) ? LVL_C : water_sum[6:0];
      water_dn  = (water_q > STEP_C) ? (water_q - STEP_C) : 7'd0;
      time_dec  = (time_q != 7'd0) ? (time_q - 7'd1) : 7'd0;
      // mode 0 hands the remaining SPIN_T over to the spin phase
      wash_end  = (mode_q == 2'd0) ? SPIN_C : 7'd0;
      mode_nxt  = (mode_q == 2'd2) ? 2'd0 : (mode_q + 2'd1);

`ifdef AUTO_POWER_OFF_EN
      idle_cnt_d = 7'd0;
      if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
         if (power_btn || start_btn || mode_btn) begin
            idle_cnt_d = 7'd0;
         end else if (tick) begin
            idle_cnt_d = idle_cnt_q + 7'd1;
            auto_off   = ((idle_cnt_q + 7'd1) >= TIMEOUT_C);
         end else begin
            idle_cnt_d = idle_cnt_q;
         end
      end
`endif

      if (state_q == S_OFF) begin
         if (power_btn) begin
            state_d = S_IDLE;
            power_d = 1'b1;
            mode_d  = 2'd0;
            total_d = total_of(2'd0);
            time_d  = total_of(2'd0);
            water_d = 7'd0;
            beep_d  = 1'b0;
         end
      end else if (power_btn || auto_off) begin
         state_d = S_OFF;
         power_d = 1'b0;
         time_d  = 7'd0;
         total_d = 7'd0;
         water_d = 7'd0;
         beep_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_btn) begin
                  state_d = (mode_q == 2'd2) ? S_SPIN : S_FILL;
               end else if (mode_btn) begin
                  mode_d  = mode_nxt;
                  total_d = total_of(mode_nxt);
                  time_d  = total_of(mode_nxt);
               end
            end
            S_FILL, S_WASH, S_DRAIN, S_SPIN: begin
               if (start_btn) begin
                  saved_d = state_q;
                  state_d = S_PAUSE;
               end else if (tick) begin
                  case (state_q)
                     S_FILL: begin
                        water_d = water_up;
                        if (water_up == LVL_C) state_d = S_WASH;
                     end
                     S_WASH: begin
                        time_d = time_dec;
                        if (time_dec <= wash_end) state_d = S_DRAIN;
                     end
                     S_DRAIN: begin
                        water_d = water_dn;
                        if (water_dn == 7'd0) begin
                           if (mode_q == 2'd0) begin
                              state_d = S_SPIN;
                           end else begin
                              state_d = S_DONE;
                              time_d  = 7'd0;
                              beep_d  = 1'b1;
                           end
                        end
                     end
                     default: begin
                        time_d = time_dec;
                        if (time_dec == 7'd0) begin
                           state_d = S_DONE;
                           beep_d  = 1'b1;
                        end
                     end
                  endcase
               end
            end
            S_DONE: begin
               if (start_btn || mode_btn) begin
                  state_d = S_IDLE;
                  time_d  = total_q;
                  beep_d  = 1'b0;
               end
            end
            S_PAUSE: begin
               if (start_btn) state_d = saved_q;
            end
            default: state_d = S_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_OFF;
         saved_q <= S_OFF;
         mode_q  <= 2'd0;
         time_q  <= 7'd0;
         total_q <= 7'd0;
         water_q <= 7'd0;
         power_q <= 1'b0;
         beep_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         mode_q  <= mode_d;
         time_q  <= time_d;
         total_q <= total_d;
         water_q <= water_d;
         power_q <= power_d;
         beep_q  <= beep_d;
      end
   end

`ifdef AUTO_POWER_OFF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_cnt_q <= 7'd0;
      else     idle_cnt_q <= idle_cnt_d;
   end
`endif

   assign power_light   = power_q;
   assign current_time  = time_q;
   assign total_time    = total_q;
   assign current_water = water_q;
   assign phase         = state_q;
   assign mode          = mode_q;
   assign done_beep     = beep_q;

endmodule

// File: tb/tb_washer_ctrl.sv
// Scoreboard bench for washer_ctrl: driver pushes model predictions, a monitor compares every cycle.
module tb_washer_ctrl;

   localparam int WASH_T    = 20;
   localparam int SPIN_T    = 10;
   localparam int WATER_LVL = 40;
   localparam int FILL_STEP = 10;

   localparam int P_OFF = 0, P_IDLE = 1, P_FILL = 2, P_WASH = 3;
   localparam int P_DRAIN = 4, P_SPIN = 5, P_DONE = 6, P_PAUSE = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0, power_btn = 1'b0, start_btn = 1'b0, mode_btn = 1'b0;
   logic       power_light, done_beep;
   logic [6:0] current_time, total_time, current_water;
   logic [2:0] phase;
   logic [1:0] mode;

   washer_ctrl #(
      .WASH_T(WASH_T), .SPIN_T(SPIN_T), .WATER_LVL(WATER_LVL), .FILL_STEP(FILL_STEP)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .power_btn(power_btn), .start_btn(start_btn),
      .mode_btn(mode_btn), .power_light(power_light), .current_time(current_time),
      .total_time(total_time), .current_water(current_water), .phase(phase),
      .mode(mode), .done_beep(done_beep)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [27:0] exp_q[$];

   // reference model: program described by phase name, remaining time and water
   int m_ph = P_OFF, m_saved = P_OFF, m_mode = 0, m_ct = 0, m_tot = 0, m_water = 0;

   function automatic int prog_total(input int md);
      if (md == 0) return WASH_T + SPIN_T;
      if (md == 1) return WASH_T;
      return SPIN_T;
   endfunction

   function automatic logic [27:0] model_out();
      return {1'(m_ph != P_OFF), 7'(m_ct), 7'(m_tot), 7'(m_water), 3'(m_ph), 2'(m_mode),
              1'(m_ph == P_DONE)};
   endfunction

   task automatic model_reset();
      m_ph = P_OFF; m_saved = P_OFF; m_mode = 0; m_ct = 0; m_tot = 0; m_water = 0;
   endtask

   task automatic model_tick();
      case (m_ph)
         P_FILL: begin
            m_water = (m_water + FILL_STEP > WATER_LVL) ? WATER_LVL : m_water + FILL_STEP;
            if (m_water == WATER_LVL) m_ph = P_WASH;
         end
         P_WASH: begin
            m_ct = m_ct - 1;
            if (m_ct == ((m_mode == 0) ? SPIN_T : 0)) m_ph = P_DRAIN;
         end
         P_DRAIN: begin
            m_water = (m_water < FILL_STEP) ? 0 : m_water - FILL_STEP;
            if (m_water == 0) begin
               if (m_mode == 0) m_ph = P_SPIN;
               else begin m_ph = P_DONE; m_ct = 0; end
            end
         end
         P_SPIN: begin
            m_ct = m_ct - 1;
            if (m_ct == 0) m_ph = P_DONE;
         end
         default: ;
      endcase
   endtask

   task automatic model_step(input bit p, input bit s, input bit m, input bit t);
      if (m_ph == P_OFF) begin
         if (p) begin
            m_ph = P_IDLE; m_mode = 0; m_tot = prog_total(0); m_ct = m_tot; m_water = 0;
         end
      end else if (p) begin
         m_ph = P_OFF; m_ct = 0; m_tot = 0; m_water = 0;
      end else if (m_ph == P_IDLE) begin
         if (s) m_ph = (m_mode == 2) ? P_SPIN : P_FILL;
         else if (m) begin
            m_mode = (m_mode + 1) % 3; m_tot = prog_total(m_mode); m_ct = m_tot;
         end
      end else if (m_ph == P_DONE) begin
         if (s || m) begin m_ph = P_IDLE; m_ct = m_tot; end
      end else if (m_ph == P_PAUSE) begin
         if (s) m_ph = m_saved;
      end else if (s) begin
         m_saved = m_ph; m_ph = P_PAUSE;
      end else if (t) begin
         model_tick();
      end
   endtask

   task automatic cyc(input bit p, input bit s, input bit m, input bit t);
      @(negedge clk);
      power_btn = p; start_btn = s; mode_btn = m; tick = t;
      model_step(p, s, m, t);
      exp_q.push_back(model_out());
   endtask

   task automatic press(input bit p, input bit s, input bit m);
      cyc(p, s, m, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic do_reset_check();
      @(posedge clk);
      #3;
      power_btn = 1'b0; start_btn = 1'b0; mode_btn = 1'b0; tick = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_phase", int'(phase), 0);
      chk("rst_power", int'(power_light), 0);
      chk("rst_time", int'(current_time), 0);
      chk("rst_total", int'(total_time), 0);
      chk("rst_water", int'(current_water), 0);
      chk("rst_mode", int'(mode), 0);
      chk("rst_beep", int'(done_beep), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : monitor
      logic [27:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {power_light, current_time, total_time, current_water, phase, mode, done_beep};
            n_checks++;
            if (a !== e) begin
               n_errors++;
               $display("FAIL scoreboard t=%0t actual pw=%0d ct=%0d tt=%0d wa=%0d ph=%0d md=%0d bp=%0d required pw=%0d ct=%0d tt=%0d wa=%0d ph=%0d md=%0d bp=%0d",
                        $time, a[27], a[26:20], a[19:13], a[12:6], a[5:3], a[2:1], a[0],
                        e[27], e[26:20], e[19:13], e[12:6], e[5:3], e[2:1], e[0]);
            end
         end
      end
   end

   initial begin : driver
      #2;
      do_reset_check();

      // reset mid-WASH
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      ticks(4 + 5);
      chk("pre_rst_time", int'(current_time), 25);
      chk("pre_rst_water", int'(current_water), 40);
      do_reset_check();
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("off_ignores_phase", int'(phase), P_OFF);

      // full mode-0 program
      press(1'b1, 1'b0, 1'b0);
      chk("on_phase", int'(phase), P_IDLE);
      chk("on_total", int'(total_time), 30);
      chk("on_time", int'(current_time), 30);
      press(1'b0, 1'b1, 1'b0);
      chk("fill_phase", int'(phase), P_FILL);
      for (int i = 0; i < 4; i++) begin
         ticks(1);
         chk("fill_water", int'(current_water), 10 * (i + 1));
      end
      chk("wash_phase", int'(phase), P_WASH);
      ticks(20);
      chk("drain_phase", int'(phase), P_DRAIN);
      chk("drain_time", int'(current_time), 10);
      ticks(4);
      chk("spin_phase", int'(phase), P_SPIN);
      chk("spin_water", int'(current_water), 0);
      ticks(10);
      chk("done_phase", int'(phase), P_DONE);
      chk("done_time", int'(current_time), 0);
      chk("done_beep", int'(done_beep), 1);

      // mode cycling and spin-only program
      press(1'b0, 1'b0, 1'b1);
      chk("done_to_idle", int'(phase), P_IDLE);
      chk("reload_time", int'(current_time), 30);
      press(1'b0, 1'b0, 1'b1);
      chk("mode1_total", int'(total_time), 20);
      press(1'b0, 1'b0, 1'b1);
      chk("mode2_total", int'(total_time), 10);
      press(1'b0, 1'b0, 1'b1);
      chk("mode0_total", int'(total_time), 30);
      chk("mode_wrap", int'(mode), 0);
      press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1, 1'b0);
      chk("spin_only_phase", int'(phase), P_SPIN);
      chk("spin_only_water", int'(current_water), 0);
      ticks(10);
      chk("spin_only_done", int'(phase), P_DONE);
      press(1'b0, 1'b1, 1'b0);
      chk("spin_only_idle_time", int'(current_time), 10);

      // pause and resume in WASH
      press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1, 1'b0);
      ticks(4 + 8);
      chk("wash_22", int'(current_time), 22);
      press(1'b0, 1'b1, 1'b0);
      chk("pause_phase", int'(phase), P_PAUSE);
      ticks(5);
      chk("pause_frozen", int'(current_time), 22);
      press(1'b0, 1'b0, 1'b1);
      chk("pause_mode_ignored", int'(mode), 0);
      press(1'b0, 1'b1, 1'b0);
      chk("resume_phase", int'(phase), P_WASH);
      ticks(1);
      chk("resume_tick", int'(current_time), 21);

      // power + start + tick together in SPIN
      ticks(11 + 4 + 3);
      chk("spin_before_off", int'(current_time), 7);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("combo_off_phase", int'(phase), P_OFF);
      chk("combo_off_time", int'(current_time), 0);
      chk("combo_off_power", int'(power_light), 0);

      // randomized traffic against the model
      for (int i = 0; i < 15000; i++) begin
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0));
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
